// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, receiver FSM states and TinyVGA PMOD pin map.
// hvsync_generator and vga_sync_receiver both draw their defaults from here.
package vga_timing_pkg;

  localparam int H_DISPLAY  = 640;
  localparam int H_FRONT    = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BACK     = 48;
  localparam int H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_DISPLAY  = 480;
  localparam int V_BOTTOM   = 10;
  localparam int V_SYNC     = 2;
  localparam int V_TOP      = 33;
  localparam int V_TOTAL    = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

  // Receiver phase points: coordinate held in the input register on the first sync-high cycle
  localparam int H_EDGE     = 657;
  localparam int V_EDGE     = 490;
  localparam int V_EDGE_H   = 1;
  localparam int LOCK_LINES = 4;

  typedef enum logic [1:0] {SEARCH, HTRACK, LOCKED} rx_state_t;

  localparam int PMOD_HS = 7;
  localparam int PMOD_B0 = 6;
  localparam int PMOD_G0 = 5;
  localparam int PMOD_R0 = 4;
  localparam int PMOD_VS = 3;
  localparam int PMOD_B1 = 2;
  localparam int PMOD_G1 = 1;
  localparam int PMOD_R1 = 0;

  function automatic logic [5:0] pmod_rgb(input logic [7:0] p);
    return {p[PMOD_R1], p[PMOD_R0], p[PMOD_G1], p[PMOD_G0], p[PMOD_B1], p[PMOD_B0]};
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync pin input register followed by rising-edge detect against the previous sample.
module vga_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q, prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= 1'b0;
      prev <= 1'b0;
    end else begin
      q    <= d;
      prev <= q;
    end
  end

  assign rise = q & ~prev;

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers hpos/vpos/rgb from the PMOD VGA bus, qualifies sync timing and tracks lock.
// Coordinates always name the pixel currently held in the rgb register.
module vga_sync_receiver #(
  parameter int H_TOTAL    = vga_timing_pkg::H_TOTAL,
  parameter int V_TOTAL    = vga_timing_pkg::V_TOTAL,
  parameter int H_DISPLAY  = vga_timing_pkg::H_DISPLAY,
  parameter int V_DISPLAY  = vga_timing_pkg::V_DISPLAY,
  parameter int H_EDGE     = vga_timing_pkg::H_EDGE,
  parameter int V_EDGE     = vga_timing_pkg::V_EDGE,
  parameter int V_EDGE_H   = vga_timing_pkg::V_EDGE_H,
  parameter int LOCK_LINES = vga_timing_pkg::LOCK_LINES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] vga_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic [5:0] rgb,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_count
);
  import vga_timing_pkg::*;

  localparam int GW = $clog2(LOCK_LINES + 1);

  logic            hs_edge, vs_edge;
  logic [5:0]      rgb_q;
  logic [9:0]      hcnt, vcnt, hcnt_nx, vcnt_nx;
  logic            h_at, v_at, h_good, h_bad, v_bad, h_wrap;
  rx_state_t       state, state_nx;
  logic [GW-1:0]   good_cnt, good_nx, good_sat;
  logic [7:0]      err_nx;

  vga_sync_edge u_hs (.clk(clk), .rst(reset), .d(vga_in[PMOD_HS]), .rise(hs_edge));
  vga_sync_edge u_vs (.clk(clk), .rst(reset), .d(vga_in[PMOD_VS]), .rise(vs_edge));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= pmod_rgb(vga_in);
  end

  // A check fails when the edge and the expected counter position disagree
  always_comb begin
    h_at   = hcnt == 10'(H_EDGE);
    v_at   = (vcnt == 10'(V_EDGE)) && (hcnt == 10'(V_EDGE_H));
    h_good = hs_edge && h_at;
    h_bad  = hs_edge ^ h_at;
    v_bad  = vs_edge ^ v_at;
    h_wrap = !hs_edge && (hcnt == 10'(H_TOTAL - 1));

    hcnt_nx = hs_edge ? 10'(H_EDGE + 1) : (h_wrap ? 10'd0 : hcnt + 10'd1);

    vcnt_nx = vcnt;
    if (vs_edge)
      vcnt_nx = h_wrap ? 10'((V_EDGE + 1) % V_TOTAL) : 10'(V_EDGE);
    else if (h_wrap)
      vcnt_nx = (vcnt == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt + 10'd1;
  end

  always_comb begin
    good_sat = (good_cnt == GW'(LOCK_LINES)) ? good_cnt : good_cnt + GW'(1);
    state_nx = state;
    good_nx  = good_cnt;
    err_nx   = err_count;
    unique case (state)
      SEARCH: begin
        if (hs_edge) begin
          state_nx = HTRACK;
          good_nx  = '0;
        end
      end
      HTRACK: begin
        if (h_good)     good_nx = good_sat;
        else if (h_bad) good_nx = '0;
        if (vs_edge && good_cnt == GW'(LOCK_LINES)) state_nx = LOCKED;
      end
      LOCKED: begin
        if (h_bad || v_bad) begin
          state_nx = HTRACK;
          good_nx  = '0;
          if (err_count != 8'hff) err_nx = err_count + 8'd1;
        end else if (h_good) begin
          good_nx = good_sat;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt      <= '0;
      vcnt      <= '0;
      state     <= SEARCH;
      good_cnt  <= '0;
      err_count <= '0;
    end else begin
      hcnt      <= hcnt_nx;
      vcnt      <= vcnt_nx;
      state     <= state_nx;
      good_cnt  <= good_nx;
      err_count <= err_nx;
    end
  end

  assign hpos        = hcnt;
  assign vpos        = vcnt;
  assign rgb         = rgb_q;
  assign locked      = state == LOCKED;
  assign pixel_valid = locked && (hcnt < 10'(H_DISPLAY)) && (vcnt < 10'(V_DISPLAY));
  assign frame_start = locked && (hcnt == 10'd0) && (vcnt == 10'd0);

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver on a scaled-down raster with random pixel data.
module tb_vga_sync_receiver;

  localparam int HT = 16, VT = 10, HD = 10, VD = 6;
  localparam int HE = 11, VE = 7, VEH = 1, LL = 4, HSW = 2;
  localparam int PX = 5, PY = 3;
  localparam logic [5:0] PAT = 6'b101101;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] vga_in = '0;
  logic [9:0] hpos, vpos;
  logic [5:0] rgb;
  logic       pixel_valid, frame_start, locked;
  logic [7:0] err_count;

  vga_sync_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_DISPLAY(HD), .V_DISPLAY(VD),
    .H_EDGE(HE), .V_EDGE(VE), .V_EDGE_H(VEH), .LOCK_LINES(LL)
  ) dut (
    .clk(clk), .reset(reset), .vga_in(vga_in), .hpos(hpos), .vpos(vpos), .rgb(rgb),
    .pixel_valid(pixel_valid), .frame_start(frame_start), .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // generator raster position and fault injection controls
  int gx = 0, gy = 0;
  bit drop_en = 0, shift_en = 0, stretch_en = 0, pat_en = 0;
  int drop_y = 4, shift_y = 8, stretch_y = 8;

  // what the receiver's input register holds, and the one before it
  bit q_hs, q_vs, p_hs, p_vs;
  logic [5:0] q_rgb;
  int q_gx, q_gy;

  // reference model: receiver's notion of position, lock and error tally
  int mx, my, mgood, merr;
  bit mtrack, mlock;

  int fs_cnt, pat_hits, fall_x, fall_y, rises;
  bit prev_locked;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mgood = 0; merr = 0; mtrack = 0; mlock = 0;
    q_hs = 0; q_vs = 0; p_hs = 0; p_vs = 0; q_rgb = '0; q_gx = -1; q_gy = -1;
    prev_locked = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hpos"}, hpos, 0);
    chk({tag, "_vpos"}, vpos, 0);
    chk({tag, "_rgb"}, rgb, 0);
    chk({tag, "_valid"}, pixel_valid, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, err_count, 0);
  endtask

  task automatic step();
    bit hs, vs, hse, vse, hat, vat, hbad, vbad, wrap;
    logic [5:0] c;
    int nmx, nmy;
    if (shift_en && gy == shift_y) hs = (gx >= HE - 2) && (gx < HE - 2 + HSW);
    else hs = (gx >= HE) && (gx < HE + HSW) && !(drop_en && gy == drop_y);
    vs = (gy == VE && gx >= VEH) || (gy == VE + 1 && gx < VEH);
    if (pat_en && gx == PX && gy == PY) c = PAT;
    else begin
      c = 6'($urandom);
      while (c == PAT) c = 6'($urandom);
    end
    vga_in = {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};

    // next receiver state from what it currently holds
    hse = q_hs && !p_hs;
    vse = q_vs && !p_vs;
    hat = (mx == HE);
    vat = (my == VE) && (mx == VEH);
    hbad = hse != hat;
    vbad = vse != vat;
    wrap = !hse && (mx == HT - 1);
    nmx = hse ? HE + 1 : (mx + 1) % HT;
    nmy = vse ? (VE + (wrap ? 1 : 0)) % VT : (wrap ? (my + 1) % VT : my);
    if (!mtrack) begin
      if (hse) begin mtrack = 1; mgood = 0; end
    end else if (!mlock) begin
      if (vse && mgood == LL) mlock = 1;
      if (hse && hat) mgood = (mgood < LL) ? mgood + 1 : LL;
      else if (hbad) mgood = 0;
    end else if (hbad || vbad) begin
      mlock = 0; mgood = 0;
      if (merr < 255) merr++;
    end else if (hse && hat && mgood < LL) mgood++;
    mx = nmx; my = nmy;

    @(posedge clk); #1;
    p_hs = q_hs; p_vs = q_vs; q_hs = hs; q_vs = vs; q_rgb = c; q_gx = gx; q_gy = gy;

    chk("hpos", hpos, mx);
    chk("vpos", vpos, my);
    chk("rgb", rgb, q_rgb);
    chk("locked", locked, mlock);
    chk("err_count", err_count, merr);
    chk("pixel_valid", pixel_valid, mlock && mx < HD && my < VD);
    chk("frame_start", frame_start, mlock && mx == 0 && my == 0);

    if (locked && !prev_locked) begin
      rises++;
      chk("rise_x", q_gx, VEH + 1);
      chk("rise_y", q_gy, VE);
    end
    if (!locked && prev_locked) begin fall_x = q_gx; fall_y = q_gy; end
    prev_locked = locked;
    if (frame_start) fs_cnt++;
    if (pat_en && rgb == PAT) begin
      pat_hits++;
      chk("pat_hpos", hpos, PX);
      chk("pat_vpos", vpos, PY);
      chk("pat_valid", pixel_valid, 1);
    end

    if (stretch_en && gy == stretch_y && gx == HT - 1) stretch_en = 0;
    else begin
      gx = (gx + 1) % HT;
      if (gx == 0) gy = (gy + 1) % VT;
    end
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      int guard = 0;
      do begin
        step();
        guard++;
      end while (!(gx == 0 && gy == 0) && guard < 2 * HT * VT);
      if (guard >= 2 * HT * VT) chk("frame_bound", guard, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    model_reset();
    #7;
    chk_zero("por");
    @(negedge clk);
    reset = 1'b0;
    gx = $urandom_range(0, HT - 1);
    gy = $urandom_range(0, VT - 1);

    // clean lock from an arbitrary raster phase
    rises = 0;
    run_frames(3);
    chk("clean_locked", locked, 1);
    chk("clean_err", err_count, 0);
    chk("clean_rises", rises, 1);

    // pixel alignment and one frame_start per frame
    fs_cnt = 0; pat_hits = 0; pat_en = 1;
    run_frames(3);
    pat_en = 0;
    chk("fs_per_frame", fs_cnt, 3);
    chk("pat_hits", pat_hits, 3);

    // dropped hsync pulse
    drop_en = 1;
    run_frames(1);
    drop_en = 0;
    chk("drop_locked", locked, 0);
    chk("drop_err", err_count, 1);
    chk("drop_fall_x", fall_x, HE + 1);
    chk("drop_fall_y", fall_y, drop_y);
    run_frames(1);
    chk("drop_relock", locked, 1);

    // one line stretched by a clock
    stretch_en = 1;
    run_frames(1);
    chk("long_locked", locked, 0);
    chk("long_err", err_count, 2);
    run_frames(1);
    chk("long_relock", locked, 1);
    chk("long_err_hold", err_count, 2);

    // asynchronous reset in the middle of a frame
    guard = 0;
    while (!(q_gx == 3 && q_gy == 2) && guard < 2 * HT * VT) begin
      step();
      guard++;
    end
    chk("mid_reset_reach", guard < 2 * HT * VT, 1);
    #1 reset = 1'b1;
    #1 chk_zero("mid_reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    run_frames(2);
    chk("reset_relock", locked, 1);
    chk("reset_err", err_count, 0);

    // one early hsync per frame, relocking in between
    shift_en = 1;
    run_frames(300);
    chk("sat_err", err_count, 255);
    run_frames(3);
    shift_en = 0;
    chk("sat_hold", err_count, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Receive-side counterpart of the project's 640x480@60 VGA sync generator and TinyVGA PMOD pin mapping. It samples the 8-bit PMOD output bus and recovers pixel coordinates (hpos/vpos) and 6-bit colour from the hsync/vsync edges. It enters and leaves lock based on checked timing and counts timing errors. It sits in the verification and loopback path, so a pattern generator's output can be checked pixel-by-pixel against its own coordinates on the same clock.

## Interface
Parameters:
- H_TOTAL, 800, clocks per line
- V_TOTAL, 525, lines per frame
- H_DISPLAY, 640, visible pixels per line
- V_DISPLAY, 480, visible lines
- H_EDGE, 657, pixel index held in the input register on the first cycle hsync is sampled high
- V_EDGE, 490, line index on the first cycle vsync is sampled high
- V_EDGE_H, 1, pixel index within that line at the vsync edge
- LOCK_LINES, 4, consecutive good lines required before lock

Ports:
- clk  in  1  pixel clock, 25.175 MHz
- reset  in  1  asynchronous, active-high
- vga_in  in  8  PMOD bus {hsync, B0, G0, R0, vsync, B1, G1, R1}
- hpos  out  10  recovered x
- vpos  out  10  recovered y
- rgb  out  6  {R1,R0,G1,G0,B1,B0}, registered
- pixel_valid  out  1  locked && hpos<H_DISPLAY && vpos<V_DISPLAY
- frame_start  out  1  locked && hpos==0 && vpos==0
- locked  out  1  timing verified
- err_count  out  8  saturating timing-error count

Reset is asynchronous and active-high. All outputs are 0 in reset, and the state machine is in SEARCH.

## Operation
- **Input stage:** vga_in is registered once into hs_q, vs_q and rgb_q. Rising edges are detected as hs_q & ~hs_prev and vs_q & ~vs_prev.
- **hcnt (= hpos):**
  - Increments every cycle and wraps from H_TOTAL-1 to 0.
  - On an hsync edge in SEARCH, or an hsync mismatch, loads H_EDGE+1.
- **vcnt (= vpos):**
  - Increments when hcnt wraps, and wraps from V_TOTAL-1 to 0.
  - On a vsync edge, is set so that vcnt==V_EDGE on the current line (no change when already in phase).
- **hsync check:**
  - Good: edge with hcnt==H_EDGE.
  - Mismatch: edge with hcnt!=H_EDGE.
  - Missing: hcnt==H_EDGE with no edge.
- **vsync check:**
  - Good: edge with vcnt==V_EDGE and hcnt==V_EDGE_H.
  - Mismatch: edge at any other position.
  - Missing: vcnt==V_EDGE, hcnt==V_EDGE_H, no edge.
- **State machine:**
  - SEARCH: locked=0. On the first hsync edge, phase-load hcnt, set good_cnt=0, go to HTRACK.
  - HTRACK: locked=0.
    - A good hsync increments good_cnt, saturating at LOCK_LINES.
    - Mismatch or missing clears good_cnt.
    - A vsync edge with good_cnt==LOCK_LINES goes to LOCKED. Otherwise the vsync edge only phase-loads vcnt.
  - LOCKED: locked=1. Any hsync or vsync mismatch or missing increments err_count (saturating at 255), clears good_cnt, goes to HTRACK and phase-loads the relevant counter.
- **Simultaneous hsync and vsync events:** evaluated independently in the same cycle. err_count adds at most 1 per cycle.

## Timing
- Pin-to-output latency for rgb is 1 clock. hpos/vpos in a cycle always name the pixel currently on rgb.
- locked rises on the clock after the qualifying vsync edge. It falls on the clock after the first failing check.
- pixel_valid and frame_start are decodes of registered state. They are glitch-free and not separately registered.
- Reset mid-frame: outputs clear immediately. After release, lock needs at least LOCK_LINES lines plus one vsync edge.
- err_count holds at 255. Only reset clears it.

## Structure
- Shared package vga_timing_pkg holds:
  - H_/V_ timing constants, also used by hvsync_generator.
  - State enum {SEARCH, HTRACK, LOCKED}.
  - PMOD bit positions.
- One sub-module, vga_sync_edge: input register plus rising-edge detect. It is instantiated twice, for hsync and vsync.

## Test plan
- **Clean lock:** reset, then drive ideal 800x525 stimulus from hvsync_generator. locked=1 one clock after the first vsync edge following ≥4 good lines. err_count=0 over 3 frames.
- **Pixel alignment:** generator drives rgb=6'b101101 only at x=100, y=50. That rgb appears with hpos=100, vpos=50, pixel_valid=1, exactly 1 clock after the pin value. frame_start is one cycle per frame.
- **Dropped hsync:** suppress one hsync pulse in line 200. locked falls on the clock after hcnt==657 of that line. err_count=1. Relock at the next qualifying vsync.
- **Long line:** stretch one line to 801 clocks. Mismatch at the next edge, err_count increments, hcnt reloads to 658, relock follows.
- **Async reset mid-frame:** assert reset at x=300, y=100. All outputs go to 0 without a clock edge. Relock occurs in the following frame.
- **Saturation:** inject 300 hsync mismatches. err_count=255 and stays there.
